afe_chan_capture: RTL and testbench
===================================

// Module: afe_chan_capture
// PURPOSE
// Consumer end of the AFE readout interface. Watches AFE_CLK/AFE_STI driven to the AFE and AFE_STO returned
// by the AFE, and runs one ADS conversion per AFE_CLK rising edge while the analog output is valid.
// Each result is tagged with its channel index and emitted as a one-cycle sample strobe, followed by a
// frame-done pulse. Sits between the AFE sequencer, the AFE/ADS pins and the sample buffer.
// PARAMETERS
// NUM_CH      64   channels per frame (1..64)
// T_SETTLE    20   CLK_100M cycles from synced AFE_CLK rise to CONVST assert (analog settle)
// T_CONVST    4    CONVST high width, cycles
// T_BUSY_MAX  80   max cycles in WAIT_BUSY before timeout error
// T_FRAME_TO  4095 max idle cycles in ARMED before frame abort (12-bit counter)
// PORTS
// CLK_100M      in   1   system clock
// CLK_RST       in   1   reset; asynchronous, active-high
// AFE_CLK       in   1   AFE shift clock (monitored copy)
// AFE_STI       in   1   shift-start pulse (monitored copy)
// AFE_STO       in   1   AFE shift-out-complete pulse
// ADC_BUSY      in   1   ADS busy; high while converting
// ADC_DATA      in   16  ADS parallel result, valid when ADC_BUSY low
// ADC_CONVST    out  1   ADS conversion start
// SAMPLE_DATA   out  16  latched result
// SAMPLE_CH     out  6   channel index of SAMPLE_DATA, 0..NUM_CH-1
// SAMPLE_VALID  out  1   one-cycle strobe; DATA/CH held until next strobe
// FRAME_DONE    out  1   one-cycle strobe at end of frame
// CAPTURE_ERR   out  1   sticky error; cleared on next accepted STI rise
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, channel counter 0; reset mid-frame aborts with no strobes.
// - AFE_CLK, AFE_STI, AFE_STO, ADC_BUSY pass 2-FF synchronisers; rise/fall detected on synced copies.
//   All references to an input edge below mean this detected edge (2-3 cycles after pin edge).
// - FSM:
//   IDLE   : STI rise -> ARMED; ch<=0, CAPTURE_ERR<=0.
//   ARMED  : AFE_CLK rise -> SETTLE; STO rise -> DONE; timer=T_FRAME_TO -> DONE, set ERR.
//   SETTLE : wait T_SETTLE cycles -> CONV.
//   CONV   : ADC_CONVST=1 for T_CONVST cycles -> WAIT_BUSY.
//   WAIT_BUSY: ADC_BUSY low for 1 cycle after >=1 cycle high, or low on entry+2 -> READ;
//            T_BUSY_MAX elapsed -> ERR set, sample dropped, ch++ and -> ARMED/DONE as in READ.
//   READ   : SAMPLE_DATA<=ADC_DATA, SAMPLE_CH<=ch, SAMPLE_VALID=1 for this cycle;
//            ch==NUM_CH-1 -> DONE, else ch++ -> ARMED.
//   DONE   : FRAME_DONE=1 one cycle -> IDLE.
// - Latency: CONVST rises T_SETTLE+1 cycles after the synced AFE_CLK rise; SAMPLE_VALID 1 cycle after busy low.
// - AFE_CLK rise outside ARMED/IDLE (overrun): ERR set, edge ignored; current conversion completes.
// - AFE_CLK rise in IDLE: ignored, no error.
// - STO rise before NUM_CH samples: DONE with ERR set (short frame).
// - STO rise during SETTLE/CONV/WAIT_BUSY: finish current sample, then DONE (ERR if short).
// - STO rise after NUM_CH samples (normally in IDLE): ignored.
// - STI rise outside IDLE: restart frame (ch<=0 -> ARMED), ERR set, FRAME_DONE not pulsed.
// - STI and AFE_CLK rise in same cycle in IDLE: STI accepted, that clock edge ignored.
// - ch is 6-bit, never wraps; NUM_CH=64 ends at ch=63.
// TESTING
// 1 Reset, STI, 64 AFE_CLK rises at 1300 ns period, busy model 60 cycles, ADC_DATA=ch*16
//   -> 64 strobes, SAMPLE_CH 0..63, DATA 0x000..0x3F0, one FRAME_DONE, ERR=0.
// 2 STO rise after 10th sample -> 10 strobes, FRAME_DONE, CAPTURE_ERR=1; next STI clears ERR.
// 3 ADC_BUSY stuck high -> CONVST pulse, no strobe, ERR=1 after 80 cycles, next AFE_CLK still captured.
// 4 Two AFE_CLK rises 30 cycles apart -> first converted, second ignored, ERR=1.
// 5 CLK_RST asserted during CONV -> ADC_CONVST 0 asynchronously, no strobes, IDLE; clean frame follows.
// 6 STI rise mid-frame after 5 samples -> next strobe SAMPLE_CH=0, ERR=1, no FRAME_DONE for first frame.

Source files
------------

// File: rtl/afe_chan_capture_if.sv
// Signal bundle between the AFE/ADS pins, the capture block and the sample buffer.
// The slave side is the capture block; the master side is whatever drives the pins.
interface afe_chan_capture_if;
   logic        afe_clk;
   logic        afe_sti;
   logic        afe_sto;
   logic        adc_busy;
   logic [15:0] adc_data;
   logic        adc_convst;
   logic [15:0] sample_data;
   logic [5:0]  sample_ch;
   logic        sample_valid;
   logic        frame_done;
   logic        capture_err;

   modport master (
      output afe_clk, afe_sti, afe_sto, adc_busy, adc_data,
      input  adc_convst, sample_data, sample_ch, sample_valid, frame_done, capture_err
   );

   modport slave (
      input  afe_clk, afe_sti, afe_sto, adc_busy, adc_data,
      output adc_convst, sample_data, sample_ch, sample_valid, frame_done, capture_err
   );
endinterface

// File: rtl/afe_chan_capture.sv
// AFE readout consumer: one ADS conversion per synced AFE_CLK rise, each result strobed
// out with its channel index, followed by a frame-done pulse.
module afe_chan_capture #(
   parameter int unsigned NUM_CH     = 64,
   parameter int unsigned T_SETTLE   = 20,
   parameter int unsigned T_CONVST   = 4,
   parameter int unsigned T_BUSY_MAX = 80,
   parameter int unsigned T_FRAME_TO = 4095
) (
   input logic               clk_100m,
   input logic               clk_rst,
   afe_chan_capture_if.slave bus
);

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StArmed    = 3'd1;
   localparam logic [2:0] StSettle   = 3'd2;
   localparam logic [2:0] StConv     = 3'd3;
   localparam logic [2:0] StWaitBusy = 3'd4;
   localparam logic [2:0] StRead     = 3'd5;
   localparam logic [2:0] StDone     = 3'd6;

   localparam logic [11:0] FrameTo    = 12'(T_FRAME_TO);
   localparam logic [11:0] SettleLast = 12'(T_SETTLE - 1);
   localparam logic [11:0] ConvLast   = 12'(T_CONVST - 1);
   localparam logic [11:0] BusyLast   = 12'(T_BUSY_MAX - 1);
   localparam logic [5:0]  LastCh     = 6'(NUM_CH - 1);

   logic [1:0] afe_clk_sync_q, sti_sync_q, sto_sync_q, busy_sync_q;
   logic       afe_clk_prev_q, sti_prev_q, sto_prev_q;
   logic       afe_clk_rise, sti_rise, sto_rise, busy_s;

   logic [2:0]  state_q, state_d;
   logic [11:0] timer_q, timer_d;
   logic [5:0]  ch_q, ch_d;
   logic        err_q, err_d;
   logic        sto_pend_q, sto_pend_d;
   logic        busy_seen_q, busy_seen_d;
   logic        advance;

   logic        convst_q;
   logic        sample_valid_q;
   logic        frame_done_q;
   logic [15:0] sample_data_q;
   logic [5:0]  sample_ch_q;

   always_ff @(posedge clk_100m or posedge clk_rst) begin
      if (clk_rst) begin
         afe_clk_sync_q <= '0;
         sti_sync_q     <= '0;
         sto_sync_q     <= '0;
         busy_sync_q    <= '0;
         afe_clk_prev_q <= 1'b0;
         sti_prev_q     <= 1'b0;
         sto_prev_q     <= 1'b0;
      end else begin
         afe_clk_sync_q <= {afe_clk_sync_q[0], bus.afe_clk};
         sti_sync_q     <= {sti_sync_q[0], bus.afe_sti};
         sto_sync_q     <= {sto_sync_q[0], bus.afe_sto};
         busy_sync_q    <= {busy_sync_q[0], bus.adc_busy};
         afe_clk_prev_q <= afe_clk_sync_q[1];
         sti_prev_q     <= sti_sync_q[1];
         sto_prev_q     <= sto_sync_q[1];
      end
   end

   assign afe_clk_rise = afe_clk_sync_q[1] & ~afe_clk_prev_q;
   assign sti_rise     = sti_sync_q[1] & ~sti_prev_q;
   assign sto_rise     = sto_sync_q[1] & ~sto_prev_q;
   assign busy_s       = busy_sync_q[1];

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      ch_d        = ch_q;
      err_d       = err_q;
      sto_pend_d  = sto_pend_q;
      busy_seen_d = busy_seen_q;
      advance     = 1'b0;

      // A clock edge while a sample is in flight is an overrun; the edge itself is dropped.
      if (afe_clk_rise && (state_q inside {StSettle, StConv, StWaitBusy, StRead, StDone})) begin
         err_d = 1'b1;
      end
      if (sto_rise && (state_q inside {StSettle, StConv, StWaitBusy, StRead})) begin
         sto_pend_d = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (sti_rise) begin
               state_d    = StArmed;
               ch_d       = '0;
               err_d      = 1'b0;
               timer_d    = '0;
               sto_pend_d = 1'b0;
            end
         end
         StArmed: begin
            if (sto_rise) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else if (afe_clk_rise) begin
               state_d = StSettle;
               timer_d = '0;
            end else if (timer_q == FrameTo) begin
               state_d = StDone;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         StSettle: begin
            if (timer_q == SettleLast) begin
               state_d = StConv;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         StConv: begin
            if (timer_q == ConvLast) begin
               state_d     = StWaitBusy;
               timer_d     = '0;
               busy_seen_d = 1'b0;
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         StWaitBusy: begin
            if (busy_s) begin
               busy_seen_d = 1'b1;
            end
            // Busy never seen high by entry+2 means the conversion already finished.
            if (!busy_s && (busy_seen_q || timer_q == 12'd2)) begin
               state_d = StRead;
            end else if (timer_q == BusyLast) begin
               err_d   = 1'b1;
               advance = 1'b1;
            end else begin
               timer_d = timer_q + 12'd1;
            end
         end
         StRead: begin
            advance = 1'b1;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (advance) begin
         if (ch_q == LastCh || sto_pend_q || sto_rise) begin
            state_d = StDone;
            if (ch_q != LastCh) begin
               err_d = 1'b1;
            end
         end else begin
            ch_d    = ch_q + 6'd1;
            state_d = StArmed;
            timer_d = '0;
         end
      end

      if (sti_rise && state_q != StIdle) begin
         state_d    = StArmed;
         ch_d       = '0;
         err_d      = 1'b1;
         timer_d    = '0;
         sto_pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk_100m or posedge clk_rst) begin
      if (clk_rst) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         ch_q        <= '0;
         err_q       <= 1'b0;
         sto_pend_q  <= 1'b0;
         busy_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         ch_q        <= ch_d;
         err_q       <= err_d;
         sto_pend_q  <= sto_pend_d;
         busy_seen_q <= busy_seen_d;
      end
   end

   // Outputs are registered off the next state so strobes align with the state they mark.
   always_ff @(posedge clk_100m or posedge clk_rst) begin
      if (clk_rst) begin
         convst_q       <= 1'b0;
         sample_valid_q <= 1'b0;
         frame_done_q   <= 1'b0;
         sample_data_q  <= '0;
         sample_ch_q    <= '0;
      end else begin
         convst_q       <= (state_d == StConv);
         sample_valid_q <= (state_d == StRead);
         frame_done_q   <= (state_d == StDone);
         if (state_d == StRead) begin
            sample_data_q <= bus.adc_data;
            sample_ch_q   <= ch_q;
         end
      end
   end

   assign bus.adc_convst   = convst_q;
   assign bus.sample_valid = sample_valid_q;
   assign bus.frame_done   = frame_done_q;
   assign bus.sample_data  = sample_data_q;
   assign bus.sample_ch    = sample_ch_q;
   assign bus.capture_err  = err_q;

endmodule

// File: tb/tb_afe_chan_capture.sv
// Bench for afe_chan_capture: frame table, corner-case sequences and random frames checked
// against the expected strobe list derived from frame length and per-conversion ADC data.
module tb_afe_chan_capture;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   afe_chan_capture_if bus ();

   afe_chan_capture #(
      .NUM_CH    (64),
      .T_SETTLE  (20),
      .T_CONVST  (4),
      .T_BUSY_MAX(80),
      .T_FRAME_TO(4095)
   ) dut (
      .clk_100m(clk),
      .clk_rst (rst),
      .bus     (bus)
   );

   typedef struct {
      int n_clk;
      int busy_len;
      bit rnd;
      int exp_n;
      bit exp_err;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] frame_data [64];
   int          busy_len   = 60;
   bit          busy_stuck = 1'b0;
   int          adc_n      = 0;
   int          conv_base  = 0;
   logic [5:0]  got_ch [$];
   logic [15:0] got_data [$];
   int          fd_cnt = 0;
   int          cv_cnt = 0;
   logic        convst_prev = 1'b0;
   int          got_base, fd_base, cv_base;

   always @(negedge clk) begin
      if (bus.sample_valid) begin
         got_ch.push_back(bus.sample_ch);
         got_data.push_back(bus.sample_data);
      end
      if (bus.frame_done) fd_cnt++;
      if (bus.adc_convst && !convst_prev) cv_cnt++;
      convst_prev = bus.adc_convst;
   end

   // ADS model: busy follows CONVST, result becomes valid as busy drops.
   initial begin
      bus.adc_busy = 1'b0;
      bus.adc_data = '0;
      forever begin
         @(posedge bus.adc_convst);
         repeat (2) @(negedge clk);
         bus.adc_busy = 1'b1;
         if (busy_stuck) begin
            while (busy_stuck) @(negedge clk);
         end else begin
            repeat (busy_len) @(negedge clk);
         end
         bus.adc_data = frame_data[(adc_n - conv_base) & 63];
         bus.adc_busy = 1'b0;
         adc_n++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sti_pulse();
      bus.afe_sti = 1'b1;
      cycles(3);
      bus.afe_sti = 1'b0;
   endtask

   task automatic sto_pulse();
      bus.afe_sto = 1'b1;
      cycles(3);
      bus.afe_sto = 1'b0;
   endtask

   task automatic afe_clk_pulse(input int hi, input int lo);
      bus.afe_clk = 1'b1;
      cycles(hi);
      bus.afe_clk = 1'b0;
      cycles(lo);
   endtask

   task automatic start_frame(input bit rnd);
      for (int i = 0; i < 64; i++) frame_data[i] = rnd ? 16'($urandom) : 16'(i * 16);
      conv_base = adc_n;
      got_base  = got_ch.size();
      fd_base   = fd_cnt;
      cv_base   = cv_cnt;
      sti_pulse();
      cycles(5);
      check("err_clear_on_sti", bus.capture_err, 1'b0);
   endtask

   task automatic check_strobes(input int exp_n, input string tag);
      check({tag, "_count"}, got_ch.size() - got_base, exp_n);
      for (int i = 0; i < exp_n && got_base + i < got_ch.size(); i++) begin
         check({tag, "_ch"}, got_ch[got_base + i], i);
         check({tag, "_data"}, got_data[got_base + i], frame_data[i]);
      end
   endtask

   task automatic run_frame(input int n, input int bl, input bit rnd, input int exp_n,
                            input bit exp_err);
      busy_len = bl;
      start_frame(rnd);
      repeat (n) afe_clk_pulse(65, 65);
      sto_pulse();
      cycles(20);
      check_strobes(exp_n, "frame");
      check("frame_done_count", fd_cnt - fd_base, 1);
      check("frame_err", bus.capture_err, exp_err);
   endtask

   initial begin
      vec_t vecs [4];
      int   w;
      int   k;
      int   bl;

      vecs[0] = '{n_clk: 64, busy_len: 60, rnd: 1'b0, exp_n: 64, exp_err: 1'b0};
      vecs[1] = '{n_clk: 10, busy_len: 60, rnd: 1'b0, exp_n: 10, exp_err: 1'b1};
      vecs[2] = '{n_clk: 1,  busy_len: 20, rnd: 1'b1, exp_n: 1,  exp_err: 1'b1};
      vecs[3] = '{n_clk: 63, busy_len: 40, rnd: 1'b1, exp_n: 63, exp_err: 1'b1};

      bus.afe_clk = 1'b0;
      bus.afe_sti = 1'b0;
      bus.afe_sto = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2);
      check("rst_convst", bus.adc_convst, 1'b0);
      check("rst_valid", bus.sample_valid, 1'b0);
      check("rst_frame_done", bus.frame_done, 1'b0);
      check("rst_err", bus.capture_err, 1'b0);
      check("rst_data", bus.sample_data, 16'h0);
      check("rst_ch", bus.sample_ch, 6'h0);

      for (int v = 0; v < 4; v++) begin
         run_frame(vecs[v].n_clk, vecs[v].busy_len, vecs[v].rnd, vecs[v].exp_n, vecs[v].exp_err);
      end

      // ADC busy stuck high: conversion dropped after timeout, next clock still captured.
      busy_len   = 60;
      busy_stuck = 1'b1;
      start_frame(1'b1);
      afe_clk_pulse(65, 25);
      check("stuck_err_not_early", bus.capture_err, 1'b0);
      check("stuck_convst_count", cv_cnt - cv_base, 1);
      cycles(40);
      check("stuck_err_set", bus.capture_err, 1'b1);
      check("stuck_no_strobe", got_ch.size() - got_base, 0);
      busy_stuck = 1'b0;
      cycles(10);
      afe_clk_pulse(65, 65);
      check("stuck_next_count", got_ch.size() - got_base, 1);
      if (got_ch.size() > got_base) begin
         check("stuck_next_ch", got_ch[got_base], 6'd1);
         check("stuck_next_data", got_data[got_base], frame_data[1]);
      end
      sto_pulse();
      cycles(20);
      check("stuck_frame_done", fd_cnt - fd_base, 1);

      // Overrun: second clock rise 30 cycles after the first.
      start_frame(1'b1);
      afe_clk_pulse(15, 15);
      afe_clk_pulse(65, 65);
      check_strobes(1, "overrun");
      check("overrun_convst_count", cv_cnt - cv_base, 1);
      check("overrun_err", bus.capture_err, 1'b1);
      sto_pulse();
      cycles(20);

      // Reset during CONV, then a clean frame.
      start_frame(1'b1);
      bus.afe_clk = 1'b1;
      w = 0;
      while (!bus.adc_convst && w < 60) begin
         cycles(1);
         w++;
      end
      check("rstconv_convst_seen", bus.adc_convst, 1'b1);
      #2 rst = 1'b1;
      bus.afe_clk = 1'b0;
      #1 check("rstconv_convst_async", bus.adc_convst, 1'b0);
      cycles(3);
      rst = 1'b0;
      cycles(150);
      check("rstconv_no_strobe", got_ch.size() - got_base, 0);
      check("rstconv_no_done", fd_cnt - fd_base, 0);
      check("rstconv_err", bus.capture_err, 1'b0);
      run_frame(64, 60, 1'b0, 64, 1'b0);

      // STI mid-frame after 5 samples restarts at channel 0 without FRAME_DONE.
      start_frame(1'b1);
      repeat (5) afe_clk_pulse(65, 65);
      sti_pulse();
      cycles(10);
      check("restart_err", bus.capture_err, 1'b1);
      afe_clk_pulse(65, 65);
      check("restart_count", got_ch.size() - got_base, 6);
      if (got_ch.size() >= got_base + 6) begin
         check("restart_ch", got_ch[got_base + 5], 6'd0);
         check("restart_data", got_data[got_base + 5], frame_data[5]);
      end
      check("restart_no_done", fd_cnt - fd_base, 0);
      sto_pulse();
      cycles(20);
      check("restart_frame_done", fd_cnt - fd_base, 1);

      // Idle ARMED timeout.
      start_frame(1'b0);
      cycles(4080);
      check("timeout_not_early", fd_cnt - fd_base, 0);
      cycles(40);
      check("timeout_done", fd_cnt - fd_base, 1);
      check("timeout_err", bus.capture_err, 1'b1);
      check("timeout_no_strobe", got_ch.size() - got_base, 0);

      // Random frame lengths and busy times against the frame-level model.
      for (int r = 0; r < 3; r++) begin
         k  = int'($urandom_range(64, 1));
         bl = int'($urandom_range(70, 5));
         run_frame(k, bl, 1'b1, k, k < 64);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
